ram_bist_controller: RTL

- Built-in self-test initiator for the 16x8 single-port RAM with synchronous write and asynchronous read.
- On a start pulse it walks every address twice:
  - write phase: fills the RAM with an LFSR-generated pattern;
  - read phase: regenerates the same pattern and compares each location against the RAM's combinational read data.
- Reports busy/done, an error count, pass/fail and the first failing address.
- Sits between the system sequencer and the RAM instance, driving the RAM's address/data_in/write_en ports directly.

---
 rtl/ram_bist_controller.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ram_bist_controller.sv
// BIST initiator for a 16x8 single-port RAM (sync write, async read).
// Writes an LFSR pattern to every address, then re-reads and compares it.
// Reports busy/done, pass/fail, mismatch count and first failing address.
module ram_bist_controller #(
  parameter int          ADDR_WIDTH = 4,
  parameter logic [7:0]  SEED       = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [7:0]            mem_data_in,
  output logic                  mem_write_en,
  input  logic [7:0]            mem_data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   error_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   ERR_ZERO  = '0;
  localparam logic [ADDR_WIDTH:0]   ERR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Pattern generator step: shift left, feedback taps 7,5,4,3.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic [ADDR_WIDTH:0]     err_q, err_d;
  logic [ADDR_WIDTH-1:0]   ffail_q, ffail_d;
  // lfsr_q always holds the pattern value belonging to addr_q.
  logic [7:0]              lfsr_q, lfsr_d;

  // State register and all registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= ADDR_ZERO;
      wdata_q <= 8'h00;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= ERR_ZERO;
      ffail_q <= ADDR_ZERO;
      lfsr_q  <= SEED;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffail_q <= ffail_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // Next-state and next-output logic; done is a single-cycle pulse by default.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    ffail_d = ffail_q;
    lfsr_d  = lfsr_q;

    case (state_q)
      ST_IDLE: begin
        we_d   = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          state_d = ST_WRITE;
          addr_d  = ADDR_ZERO;
          wdata_d = SEED;
          we_d    = 1'b1;
          busy_d  = 1'b1;
          err_d   = ERR_ZERO;
          ffail_d = ADDR_ZERO;
          pass_d  = 1'b0;
          lfsr_d  = SEED;
        end
      end

      ST_WRITE: begin
        // The RAM captures addr_q/wdata_q at this edge; line up the next one.
        if (addr_q == ADDR_MAX) begin
          state_d = ST_READ;
          addr_d  = ADDR_ZERO;
          we_d    = 1'b0;
          lfsr_d  = SEED;
        end else begin
          addr_d  = addr_q + ADDR_ONE;
          lfsr_d  = lfsr_next(lfsr_q);
          wdata_d = lfsr_next(lfsr_q);
        end
      end

      ST_READ: begin
        // Read data is combinational from the RAM for the current address.
        if (mem_data_out != lfsr_q) begin
          err_d = err_q + ERR_ONE;
          if (err_q == ERR_ZERO) begin
            ffail_d = addr_q;
          end
        end
        if (addr_q == ADDR_MAX) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
        end else begin
          addr_d = addr_q + ADDR_ONE;
          lfsr_d = lfsr_next(lfsr_q);
        end
      end

      ST_DONE: begin
        // err_q already includes the compare at the last address.
        done_d  = 1'b1;
        busy_d  = 1'b0;
        we_d    = 1'b0;
        pass_d  = (err_q == ERR_ZERO);
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        we_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign mem_address     = addr_q;
  assign mem_data_in     = wdata_q;
  assign mem_write_en    = we_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign error_count     = err_q;
  assign first_fail_addr = ffail_q;

endmodule
